// File: rtl/stream_req_sched_if.sv
// Request/response bundle between the stream engines, the scheduler and the tag interface.
// The scheduler connects through the slave modport; the environment connects through the master modport.
interface stream_req_sched_if #(
    parameter int addr_width   = 64,
    parameter int nstrms       = 64,
    parameter int nstrms_width = $clog2(nstrms)
);
    logic [nstrms-1:0]            i_req_v;
    logic [nstrms-1:0]            i_req_r;
    logic [nstrms*addr_width-1:0] i_req_ea;
    logic                         o_req_v;
    logic                         o_req_r;
    logic [nstrms_width-1:0]      o_req_sid;
    logic [addr_width-1:0]        o_req_ea;
    logic                         i_cpl_v;
    logic [nstrms_width-1:0]      i_cpl_sid;
    logic                         o_idle;
    logic                         o_err;

    modport master (
        output i_req_v, i_req_ea, o_req_r, i_cpl_v, i_cpl_sid,
        input  i_req_r, o_req_v, o_req_sid, o_req_ea, o_idle, o_err
    );

    modport slave (
        input  i_req_v, i_req_ea, o_req_r, i_cpl_v, i_cpl_sid,
        output i_req_r, o_req_v, o_req_sid, o_req_ea, o_idle, o_err
    );
endinterface

// File: rtl/stream_req_sched.sv
// Round-robin scheduler that picks one stream request per cycle into a one-entry output register.
// Each stream is limited to max_out outstanding requests by a credit counter.
module stream_req_sched #(
    parameter int addr_width   = 64,
    parameter int nstrms       = 64,
    parameter int nstrms_width = $clog2(nstrms),
    parameter int max_out      = 4,
    parameter int cnt_width    = $clog2(max_out + 1)
) (
    input logic              clk,
    input logic              reset,
    stream_req_sched_if.slave bus
);
    logic [cnt_width-1:0]    cnt [nstrms];
    logic [nstrms_width-1:0] ptr;
    logic [nstrms_width-1:0] sid_q;
    logic [addr_width-1:0]   ea_q;
    logic                    req_v_q;
    logic                    err_q;

    logic                    load;
    logic                    gnt_v;
    logic [nstrms_width-1:0] gnt_id;
    logic [nstrms_width-1:0] next_ptr;
    logic [addr_width-1:0]   gnt_ea;
    logic [nstrms-1:0]       elig;
    logic [nstrms-1:0]       cpl_hit;
    logic [nstrms-1:0]       cnt_zero;
    logic [nstrms-1:0]       gnt_oh;
    logic                    underflow;
    logic [nstrms_width:0]   idx;

    assign load = !req_v_q || bus.o_req_r;

    always_comb begin
        elig     = '0;
        cpl_hit  = '0;
        cnt_zero = '0;
        for (int s = 0; s < nstrms; s++) begin
            elig[s]     = bus.i_req_v[s] && (cnt[s] < cnt_width'(max_out));
            cnt_zero[s] = (cnt[s] == '0);
            cpl_hit[s]  = bus.i_cpl_v && (bus.i_cpl_sid == nstrms_width'(s));
        end
    end

    // Rotating priority scan starting at ptr, wrapping past nstrms-1.
    always_comb begin
        gnt_v  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int k = 0; k < nstrms; k++) begin
            idx = {1'b0, ptr} + (nstrms_width + 1)'(k);
            if (idx >= (nstrms_width + 1)'(nstrms))
                idx = idx - (nstrms_width + 1)'(nstrms);
            if (!gnt_v && elig[idx[nstrms_width-1:0]]) begin
                gnt_v  = 1'b1;
                gnt_id = idx[nstrms_width-1:0];
            end
        end
    end

    always_comb begin
        gnt_ea = '0;
        for (int s = 0; s < nstrms; s++) begin
            if (gnt_id == nstrms_width'(s))
                gnt_ea = bus.i_req_ea[s*addr_width +: addr_width];
        end
    end

    // Ready is held low while reset is asserted so nothing is consumed from the streams.
    always_comb begin
        gnt_oh = '0;
        if (reset && load && gnt_v)
            gnt_oh[gnt_id] = 1'b1;
    end

    assign next_ptr  = (gnt_id == nstrms_width'(nstrms - 1)) ? '0 : gnt_id + nstrms_width'(1);

    // Out-of-range ids hit no stream and count as underflow along with returns to an empty counter.
    assign underflow = bus.i_cpl_v && ((cpl_hit == '0) || ((cpl_hit & cnt_zero) != '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_v_q <= 1'b0;
            sid_q   <= '0;
            ea_q    <= '0;
            ptr     <= '0;
            err_q   <= 1'b0;
        end else begin
            if (load) begin
                req_v_q <= gnt_v;
                if (gnt_v) begin
                    sid_q <= gnt_id;
                    ea_q  <= gnt_ea;
                    ptr   <= next_ptr;
                end
            end
            if (underflow)
                err_q <= 1'b1;
        end
    end

    // Credit taken at grant, returned on completion; both in one cycle cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < nstrms; s++)
                cnt[s] <= '0;
        end else begin
            for (int s = 0; s < nstrms; s++) begin
                if (gnt_oh[s] && !(cpl_hit[s] && !cnt_zero[s]))
                    cnt[s] <= cnt[s] + cnt_width'(1);
                else if (!gnt_oh[s] && cpl_hit[s] && !cnt_zero[s])
                    cnt[s] <= cnt[s] - cnt_width'(1);
            end
        end
    end

    assign bus.i_req_r   = gnt_oh;
    assign bus.o_req_v   = req_v_q;
    assign bus.o_req_sid = sid_q;
    assign bus.o_req_ea  = ea_q;
    assign bus.o_err     = err_q;
    assign bus.o_idle    = !req_v_q && (&cnt_zero);
endmodule

// File: tb/tb_stream_req_sched.sv
// Directed bench for stream_req_sched: 4 streams, 2 credits each, ea[s] = 0x1000*(s+1).
module tb_stream_req_sched;
    localparam int AW  = 32;
    localparam int NS  = 4;
    localparam int NSW = 2;
    localparam int MO  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    stream_req_sched_if #(.addr_width(AW), .nstrms(NS), .nstrms_width(NSW)) bus ();

    stream_req_sched #(
        .addr_width(AW), .nstrms(NS), .nstrms_width(NSW), .max_out(MO), .cnt_width(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int sid, input int ea);
        chk({tag, "_v"},   64'(bus.o_req_v),   64'(1));
        chk({tag, "_sid"}, 64'(bus.o_req_sid), 64'(sid));
        chk({tag, "_ea"},  64'(bus.o_req_ea),  64'(ea));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_req_v   = '0;
        bus.i_req_ea  = '0;
        bus.o_req_r   = 1'b0;
        bus.i_cpl_v   = 1'b0;
        bus.i_cpl_sid = '0;
        for (int s = 0; s < NS; s++)
            bus.i_req_ea[s*AW +: AW] = AW'(32'h1000 * (s + 1));

        #2;
        chk("rst_v",    64'(bus.o_req_v), 64'(0));
        chk("rst_idle", 64'(bus.o_idle),  64'(1));
        chk("rst_err",  64'(bus.o_err),   64'(0));
        chk("rst_rdy",  64'(bus.i_req_r), 64'(0));
        tick;
        tick;
        reset = 1'b1;
        #1;
        chk("rel_v",    64'(bus.o_req_v),   64'(0));
        chk("rel_idle", 64'(bus.o_idle),    64'(1));
        chk("rel_err",  64'(bus.o_err),     64'(0));
        chk("rel_sid",  64'(bus.o_req_sid), 64'(0));
        chk("rel_ea",   64'(bus.o_req_ea),  64'(0));

        // Completion with nothing outstanding
        bus.i_cpl_v   = 1'b1;
        bus.i_cpl_sid = 2'd3;
        tick;
        bus.i_cpl_v = 1'b0;
        chk("uf_err",  64'(bus.o_err),  64'(1));
        chk("uf_idle", 64'(bus.o_idle), 64'(1));

        // All streams requesting: 0,1,2,3,0,1,2,3 then every stream at max credits
        bus.i_req_v = 4'hF;
        bus.o_req_r = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_rdy", 64'(bus.i_req_r), 64'(1) << (k % 4));
            tick;
            chk_out("rr", k % 4, 32'h1000 * ((k % 4) + 1));
        end
        #1;
        chk("rr_stop_rdy", 64'(bus.i_req_r), 64'(0));
        tick;
        bus.i_req_v = '0;
        chk("rr_drain_v",   64'(bus.o_req_v), 64'(0));
        chk("rr_busy_idle", 64'(bus.o_idle),  64'(0));

        // Return every credit
        for (int s = 0; s < NS; s++) begin
            for (int j = 0; j < MO; j++) begin
                bus.i_cpl_v   = 1'b1;
                bus.i_cpl_sid = NSW'(s);
                tick;
            end
        end
        bus.i_cpl_v = 1'b0;
        chk("ret_idle", 64'(bus.o_idle), 64'(1));
        chk("ret_err",  64'(bus.o_err),  64'(1));

        // Only stream 2: two grants, blocked, one completion frees one more
        bus.i_req_v = 4'b0100;
        #1;
        chk("s2_rdy0", 64'(bus.i_req_r), 64'(4));
        tick;
        chk_out("s2_g0", 2, 32'h3000);
        #1;
        chk("s2_rdy1", 64'(bus.i_req_r), 64'(4));
        tick;
        chk_out("s2_g1", 2, 32'h3000);
        #1;
        chk("s2_block", 64'(bus.i_req_r), 64'(0));
        tick;
        chk("s2_block_v", 64'(bus.o_req_v), 64'(0));
        bus.i_cpl_v   = 1'b1;
        bus.i_cpl_sid = 2'd2;
        #1;
        chk("s2_cpl_rdy", 64'(bus.i_req_r), 64'(0));
        tick;
        bus.i_cpl_v = 1'b0;
        chk("s2_cpl_v", 64'(bus.o_req_v), 64'(0));
        #1;
        chk("s2_regrant_rdy", 64'(bus.i_req_r), 64'(4));
        tick;
        chk_out("s2_g2", 2, 32'h3000);

        // Backpressure holds stream 2's request; release grants stream 3 in the same cycle
        bus.o_req_r = 1'b0;
        bus.i_req_v = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_rdy", 64'(bus.i_req_r), 64'(0));
            tick;
            chk_out("bp_hold", 2, 32'h3000);
        end
        bus.o_req_r = 1'b1;
        #1;
        chk("bp_rel_rdy", 64'(bus.i_req_r), 64'(8));
        tick;
        chk_out("bp_rel", 3, 32'h4000);

        // Stream 1 driven to max, then a completion arrives while it still requests
        bus.i_req_v = 4'b0010;
        #1;
        chk("sm_rdy0", 64'(bus.i_req_r), 64'(2));
        tick;
        chk_out("sm_g0", 1, 32'h2000);
        #1;
        chk("sm_rdy1", 64'(bus.i_req_r), 64'(2));
        tick;
        chk_out("sm_g1", 1, 32'h2000);
        bus.i_cpl_v   = 1'b1;
        bus.i_cpl_sid = 2'd1;
        #1;
        chk("sm_same_rdy", 64'(bus.i_req_r), 64'(0));
        tick;
        bus.i_cpl_v = 1'b0;
        chk("sm_same_v", 64'(bus.o_req_v), 64'(0));
        #1;
        chk("sm_next_rdy", 64'(bus.i_req_r), 64'(2));
        tick;
        chk_out("sm_g2", 1, 32'h2000);
        #1;
        chk("sm_max_rdy", 64'(bus.i_req_r), 64'(0));

        // Burst then asynchronous reset between clock edges
        bus.i_req_v = 4'hF;
        tick;
        chk_out("ar_pre", 3, 32'h4000);
        #3;
        reset = 1'b0;
        #1;
        chk("ar_v",    64'(bus.o_req_v), 64'(0));
        chk("ar_rdy",  64'(bus.i_req_r), 64'(0));
        chk("ar_idle", 64'(bus.o_idle),  64'(1));
        chk("ar_err",  64'(bus.o_err),   64'(0));
        tick;
        chk("ar_hold_v", 64'(bus.o_req_v), 64'(0));
        #3;
        reset = 1'b1;
        #1;
        chk("ar_rdy0", 64'(bus.i_req_r), 64'(1));
        tick;
        chk_out("ar_g0", 0, 32'h1000);
        #1;
        chk("ar_rdy1", 64'(bus.i_req_r), 64'(2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
